// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports, one access outstanding.
// Data wins ties; a saturating counter forces fetch after STARVE_MAX data grants while fetch waits.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [WIDTH-1:0]      if_rdata,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0]      dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [WIDTH-1:0]      dm_rdata,
    output logic                  dm_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [WIDTH-1:0]      mem_rdata
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, RD_IF, RD_DM} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          idle, pick_dm, pick_if, rd_if, rd_dm;
    // Everything is gated by rst so outputs are quiet during the asynchronous reset pulse.
    always_comb begin
        idle      = ~rst & (state_q == IDLE);
        rd_if     = ~rst & (state_q == RD_IF);
        rd_dm     = ~rst & (state_q == RD_DM);
        pick_dm   = idle & dm_req & (~if_req | (starve_q < CW'(STARVE_MAX)));
        pick_if   = idle & if_req & ~pick_dm;
        mem_req   = pick_dm | pick_if;
        mem_we    = pick_dm & dm_we;
        mem_addr  = pick_dm ? dm_addr : pick_if ? if_addr : '0;
        mem_wdata = mem_we ? dm_wdata : '0;
        dm_gnt    = pick_dm & mem_ready;
        if_gnt    = pick_if & mem_ready;
        if_rvalid = rd_if & mem_rvalid;
        dm_rvalid = rd_dm & mem_rvalid;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
        if_stall  = ~rst & ((if_req & ~if_gnt) | (rd_if & ~mem_rvalid));
        dm_stall  = ~rst & ((dm_req & ~dm_gnt) | (rd_dm & ~mem_rvalid));
        state_d   = if_gnt ? RD_IF : (dm_gnt & ~dm_we) ? RD_DM : ((rd_if | rd_dm) & mem_rvalid) ? IDLE : state_q;
        starve_d  = (if_gnt | (idle & ~if_req)) ? '0 :
                    (dm_gnt & (starve_q < CW'(STARVE_MAX))) ? starve_q + CW'(1) : starve_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic against a memory model, checked by a
// cycle-level arbitration model and per-port response scoreboards.
module tb_mem_port_arbiter;
    localparam int SM = 4;
    logic        clk = 0, rst = 1;
    logic        if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0, mem_rvalid = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic        if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, dm_stall, mem_req, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    int          n_cmp = 0, n_err = 0;
    int          rdy_mode = 0, lat_lo = 0, lat_hi = 2, stray_en = 1;
    logic [31:0] ref_mem [128];
    logic [31:0] phys [128];
    logic [31:0] if_q [$];
    logic [31:0] dm_q [$];
    logic        g_if, g_dm, g_ifrv, g_dmrv;

    mem_port_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stores land in the reference image when granted, so an abandoned store never counts.
    task automatic step();
        @(negedge clk);
        g_if = if_gnt; g_dm = dm_gnt; g_ifrv = if_rvalid; g_dmrv = dm_rvalid;
        if (g_dm && dm_we) ref_mem[dm_addr[8:2]] = dm_wdata;
        @(posedge clk); #1;
    endtask

    task automatic req_if(input logic [31:0] a);
        if_req = 1; if_addr = a;
        if_q.push_back(ref_mem[a[8:2]]);
    endtask

    task automatic req_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
        dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = d;
        if (!we) dm_q.push_back(ref_mem[a[8:2]]);
    endtask

    task automatic do_reset();
        rst = 1; if_req = 0; dm_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Memory environment: accepts on mem_req & mem_ready, answers reads after lat extra cycles.
    initial begin
        logic        acc_rd, acc_wr, pend;
        logic [31:0] a, wd;
        logic [6:0]  pa;
        int          lat;
        pend = 0; pa = 0; lat = 0;
        forever begin
            @(negedge clk);
            acc_rd = mem_req & mem_ready & ~mem_we;
            acc_wr = mem_req & mem_ready & mem_we;
            a = mem_addr; wd = mem_wdata;
            @(posedge clk); #2;
            if (acc_wr) phys[a[8:2]] = wd;
            if (acc_rd) begin pend = 1; pa = a[8:2]; lat = int'($urandom_range(lat_hi, lat_lo)); end
            mem_rvalid = 0; mem_rdata = $urandom;
            if (pend) begin
                if (lat == 0) begin mem_rvalid = 1; mem_rdata = phys[pa]; pend = 0; end
                else lat--;
            end else if (stray_en != 0 && $urandom_range(7, 0) == 0) mem_rvalid = 1;
            mem_ready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(3, 0) != 0);
        end
    end

    // Monitor: transaction-level arbitration model plus response scoreboards.
    initial begin
        int   owner, streak;
        logic pdm, pif, eig, edg;
        owner = 0; streak = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs_zero", 32'(|{if_gnt, if_rvalid, if_rdata, if_stall, dm_gnt, dm_rvalid,
                    dm_rdata, dm_stall, mem_req, mem_we, mem_addr, mem_wdata}), 0);
                owner = 0; streak = 0;
                if_q.delete(); dm_q.delete();
            end else begin
                pdm = owner == 0 && dm_req && (!if_req || streak < SM);
                pif = owner == 0 && if_req && !pdm;
                eig = pif && mem_ready;
                edg = pdm && mem_ready;
                chk("if_gnt", 32'(if_gnt), 32'(eig));
                chk("dm_gnt", 32'(dm_gnt), 32'(edg));
                chk("mem_req", 32'(mem_req), 32'(pdm || pif));
                if (pdm || pif) begin
                    chk("mem_addr", mem_addr, pdm ? dm_addr : if_addr);
                    chk("mem_we", 32'(mem_we), 32'(pdm && dm_we));
                    if (pdm && dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
                end
                chk("if_rvalid", 32'(if_rvalid), 32'(owner == 1 && mem_rvalid));
                chk("dm_rvalid", 32'(dm_rvalid), 32'(owner == 2 && mem_rvalid));
                chk("if_stall", 32'(if_stall), 32'((if_req && !eig) || (owner == 1 && !mem_rvalid)));
                chk("dm_stall", 32'(dm_stall), 32'((dm_req && !edg) || (owner == 2 && !mem_rvalid)));
                if (if_rvalid) chk("if_rdata", if_rdata, if_q.size() > 0 ? if_q.pop_front() : 32'hxxxxxxxx);
                else chk("if_rdata_idle", if_rdata, 0);
                if (dm_rvalid) chk("dm_rdata", dm_rdata, dm_q.size() > 0 ? dm_q.pop_front() : 32'hxxxxxxxx);
                else chk("dm_rdata_idle", dm_rdata, 0);
                if (owner != 0) begin
                    if (mem_rvalid) owner = 0;
                end else begin
                    if (eig) owner = 1;
                    else if (edg && !dm_we) owner = 2;
                    if (eig || !if_req) streak = 0;
                    else if (edg) streak = streak < SM ? streak + 1 : SM;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, nb, rv, ig, t4;
        for (int i = 0; i < 128; i++) begin ref_mem[i] = $urandom; phys[i] = ref_mem[i]; end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        // Random traffic: fetch in 0x000-0x0FF, data in 0x100-0x1FF.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (g_if) if_req = 0;
            if (g_dm) dm_req = 0;
            if (!if_req && $urandom_range(2, 0) == 0) req_if(32'(4 * $urandom_range(63, 0)));
            if (!dm_req && $urandom_range(2, 0) == 0)
                req_dm(1'($urandom_range(1, 0)), 32'(256 + 4 * $urandom_range(63, 0)), $urandom);
        end
        rdy_mode = 1; stray_en = 0; lat_lo = 1; lat_hi = 1;
        do_reset();
        // Single fetch: grant in cycle 0, data in cycle 2.
        ref_mem[0] = 32'h00500093; phys[0] = 32'h00500093;
        req_if(32'h0);
        step(); chk("t1_if_gnt", 32'(g_if), 1); if_req = 0;
        step(); chk("t1_no_rvalid_c1", 32'(g_ifrv), 0);
        step(); chk("t1_rvalid_c2", 32'(g_ifrv), 1);
        step();
        // Tie: data load wins, fetch follows the cycle after dm_rvalid.
        req_if(32'h4); req_dm(0, 32'h100, 0);
        step(); chk("t2_dm_gnt", 32'(g_dm), 1); chk("t2_if_gnt", 32'(g_if), 0); dm_req = 0;
        rv = -1; ig = -1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (g_dmrv && rv < 0) rv = k;
            if (g_if && ig < 0) begin ig = k; if_req = 0; end
        end
        chk("t2_dm_rvalid_cycle", 32'(rv), 2);
        chk("t2_if_after_rvalid", 32'(ig), 3);
        // Starvation: four stores, then fetch forced, then remaining stores.
        lat_lo = 0; lat_hi = 0;
        req_if(32'h8); ns = 0; nb = -1;
        req_dm(1, 32'h110, $urandom);
        for (int k = 0; k < 24 && (ns < 6 || if_req); k++) begin
            step();
            if (g_if) begin nb = ns; if_req = 0; end
            if (g_dm) begin
                ns++;
                if (ns < 6) req_dm(1, 32'(32'h110 + 4 * ns), $urandom); else dm_req = 0;
            end
        end
        chk("t3_stores_before_fetch", 32'(nb), SM);
        chk("t3_all_stores", 32'(ns), 6);
        step();
        // Store completes without response, then read it back.
        req_dm(1, 32'h104, 32'hDEADBEEF);
        step(); chk("t4_store_gnt", 32'(g_dm), 1); dm_req = 0;
        step(); chk("t4_no_dm_rvalid", 32'(g_dmrv), 0);
        req_dm(0, 32'h104, 0);
        t4 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (g_dm) dm_req = 0;
            if (g_dmrv) t4++;
        end
        chk("t4_readback_count", 32'(t4), 1);
        // Reset while a load is outstanding; the late response must be dropped.
        lat_lo = 3; lat_hi = 3;
        req_dm(0, 32'h10C, 0);
        step(); chk("t5_load_gnt", 32'(g_dm), 1); dm_req = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin step(); chk("t5_no_late_rvalid", 32'(g_dmrv), 0); end
        // Memory back-pressure: request held, granted on first ready.
        lat_lo = 0; lat_hi = 0; rdy_mode = 2;
        req_dm(1, 32'h108, 32'h12345678);
        for (int k = 0; k < 3; k++) begin step(); chk("t6_no_gnt", 32'(g_dm), 0); end
        rdy_mode = 1;
        step(); chk("t6_gnt_on_ready", 32'(g_dm), 1); dm_req = 0;
        repeat (6) step();
        chk("if_responses_outstanding", 32'(if_q.size()), 0);
        chk("dm_responses_outstanding", 32'(dm_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
